// File: rtl/piarb_wrr_sch.sv
// Weighted round-robin dequeue scheduler: tracks per-queue non-empty state from QM acks and
// issues at most one dequeue per cycle, capped at MAX_INFLIGHT requests awaiting a depth ack.
module piarb_wrr_sch #(
  parameter int NUM_QUEUES     = 32,
  parameter int QUEUE_ID_NBITS = 5,
  parameter int WEIGHT_NBITS   = 4,
  parameter int MAX_INFLIGHT   = 4,
  localparam int CNT_NBITS     = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sch_en,
  input  logic                      cfg_wr,
  input  logic [QUEUE_ID_NBITS-1:0] cfg_qid,
  input  logic [WEIGHT_NBITS-1:0]   cfg_weight,
  input  logic                      qm_enq_ack,
  input  logic                      qm_enq_to_empty,
  input  logic [QUEUE_ID_NBITS-1:0] qm_enq_ack_qid,
  input  logic                      sch_deq_depth_ack,
  input  logic                      sch_deq_depth_from_emptyp2,
  output logic                      sch_deq,
  output logic [QUEUE_ID_NBITS-1:0] sch_deq_qid,
  output logic [CNT_NBITS-1:0]      inflight_cnt,
  output logic                      err_unexp_ack
);

  localparam int PTR_NBITS = $clog2(MAX_INFLIGHT);

  logic [NUM_QUEUES-1:0]     r_active;
  logic [NUM_QUEUES-1:0]     r_pending;
  logic [WEIGHT_NBITS-1:0]   r_weight [NUM_QUEUES];
  logic [WEIGHT_NBITS-1:0]   r_credit [NUM_QUEUES];
  logic [QUEUE_ID_NBITS-1:0] r_ptr;
  logic [QUEUE_ID_NBITS-1:0] r_fifo [MAX_INFLIGHT];
  logic [PTR_NBITS-1:0]      r_wr_ptr;
  logic [PTR_NBITS-1:0]      r_rd_ptr;
  logic [CNT_NBITS-1:0]      r_cnt;
  logic                      r_deq;
  logic [QUEUE_ID_NBITS-1:0] r_deq_qid;
  logic                      r_err;

  logic [NUM_QUEUES-1:0]     w_eligible;
  logic                      w_ack_ok;
  logic                      w_ack_bad;
  logic [QUEUE_ID_NBITS-1:0] w_head_qid;
  logic [QUEUE_ID_NBITS-1:0] w_idx;
  logic                      w_found;
  logic [QUEUE_ID_NBITS-1:0] w_grant_qid;
  logic                      w_grant;
  logic                      w_credit_last;
  logic [QUEUE_ID_NBITS-1:0] w_ptr_nxt;
  logic [WEIGHT_NBITS-1:0]   w_cfg_weight_eff;
  logic [NUM_QUEUES-1:0]     w_set_mask;
  logic [NUM_QUEUES-1:0]     w_clr_mask;
  logic [NUM_QUEUES-1:0]     w_pop_mask;
  logic [NUM_QUEUES-1:0]     w_push_mask;

  function automatic logic [NUM_QUEUES-1:0] qid_onehot(input logic [QUEUE_ID_NBITS-1:0] qid);
    qid_onehot = {{(NUM_QUEUES-1){1'b0}}, 1'b1} << qid;
  endfunction

  assign w_eligible       = r_active & ~r_pending;
  assign w_ack_ok         = sch_deq_depth_ack & (r_cnt != {CNT_NBITS{1'b0}});
  assign w_ack_bad        = sch_deq_depth_ack & (r_cnt == {CNT_NBITS{1'b0}});
  assign w_head_qid       = r_fifo[r_rd_ptr];
  assign w_cfg_weight_eff = (cfg_weight == {WEIGHT_NBITS{1'b0}}) ? {{(WEIGHT_NBITS-1){1'b0}}, 1'b1}
                                                                  : cfg_weight;

  // Rotating priority search: first eligible queue at or after the RR pointer.
  always_comb begin
    w_found     = 1'b0;
    w_grant_qid = {QUEUE_ID_NBITS{1'b0}};
    w_idx       = {QUEUE_ID_NBITS{1'b0}};
    for (int i = 0; i < NUM_QUEUES; i++) begin
      w_idx = QUEUE_ID_NBITS'((int'(r_ptr) + i) % NUM_QUEUES);
      if (!w_found && w_eligible[w_idx]) begin
        w_found     = 1'b1;
        w_grant_qid = w_idx;
      end else begin
        w_found     = w_found;
        w_grant_qid = w_grant_qid;
      end
    end
  end

  // Grant qualification, pointer advance and per-queue bitmap update masks.
  always_comb begin
    w_grant       = sch_en & w_found & (r_cnt < CNT_NBITS'(MAX_INFLIGHT));
    w_credit_last = (r_credit[w_grant_qid] <= {{(WEIGHT_NBITS-1){1'b0}}, 1'b1});
    w_ptr_nxt     = r_ptr;
    if (w_grant && w_credit_last) begin
      w_ptr_nxt = (w_grant_qid == QUEUE_ID_NBITS'(NUM_QUEUES - 1)) ? {QUEUE_ID_NBITS{1'b0}}
                                                                   : w_grant_qid + QUEUE_ID_NBITS'(1);
    end else if (w_grant) begin
      w_ptr_nxt = w_grant_qid;
    end else begin
      w_ptr_nxt = r_ptr;
    end
    w_set_mask  = (qm_enq_ack & qm_enq_to_empty) ? qid_onehot(qm_enq_ack_qid) : {NUM_QUEUES{1'b0}};
    w_clr_mask  = (w_ack_ok & ~sch_deq_depth_from_emptyp2) ? qid_onehot(w_head_qid) : {NUM_QUEUES{1'b0}};
    w_pop_mask  = w_ack_ok ? qid_onehot(w_head_qid) : {NUM_QUEUES{1'b0}};
    w_push_mask = w_grant ? qid_onehot(w_grant_qid) : {NUM_QUEUES{1'b0}};
  end

  // Issue outputs, queue bitmaps, latency FIFO and in-flight count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deq     <= 1'b0;
      r_deq_qid <= {QUEUE_ID_NBITS{1'b0}};
      r_active  <= {NUM_QUEUES{1'b0}};
      r_pending <= {NUM_QUEUES{1'b0}};
      r_wr_ptr  <= {PTR_NBITS{1'b0}};
      r_rd_ptr  <= {PTR_NBITS{1'b0}};
      r_cnt     <= {CNT_NBITS{1'b0}};
      r_err     <= 1'b0;
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        r_fifo[i] <= {QUEUE_ID_NBITS{1'b0}};
      end
    end else begin
      r_deq <= w_grant;
      if (w_grant) begin
        r_deq_qid                   <= w_grant_qid;
        r_fifo[r_wr_ptr]            <= w_grant_qid;
        r_wr_ptr                    <= (r_wr_ptr == PTR_NBITS'(MAX_INFLIGHT - 1)) ? {PTR_NBITS{1'b0}}
                                                                                 : r_wr_ptr + PTR_NBITS'(1);
      end
      if (w_ack_ok) begin
        r_rd_ptr <= (r_rd_ptr == PTR_NBITS'(MAX_INFLIGHT - 1)) ? {PTR_NBITS{1'b0}}
                                                               : r_rd_ptr + PTR_NBITS'(1);
      end
      // Set beats clear on the same queue.
      r_active  <= (r_active & ~w_clr_mask) | w_set_mask;
      r_pending <= (r_pending & ~w_pop_mask) | w_push_mask;
      case ({w_grant, w_ack_ok})
        2'b10:   r_cnt <= r_cnt + CNT_NBITS'(1);
        2'b01:   r_cnt <= r_cnt - CNT_NBITS'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_ack_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  // Weights, credits and RR pointer; a weight write overrides a same-cycle grant decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= {QUEUE_ID_NBITS{1'b0}};
      for (int q = 0; q < NUM_QUEUES; q++) begin
        r_weight[q] <= {{(WEIGHT_NBITS-1){1'b0}}, 1'b1};
        r_credit[q] <= {{(WEIGHT_NBITS-1){1'b0}}, 1'b1};
      end
    end else begin
      r_ptr <= w_ptr_nxt;
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (cfg_wr && (cfg_qid == QUEUE_ID_NBITS'(q))) begin
          r_weight[q] <= w_cfg_weight_eff;
          r_credit[q] <= w_cfg_weight_eff;
        end else if (w_grant && (w_grant_qid == QUEUE_ID_NBITS'(q))) begin
          r_credit[q] <= w_credit_last ? r_weight[q] : r_credit[q] - WEIGHT_NBITS'(1);
        end
      end
    end
  end

  assign sch_deq       = r_deq;
  assign sch_deq_qid   = r_deq_qid;
  assign inflight_cnt  = r_cnt;
  assign err_unexp_ack = r_err;

endmodule

// File: tb/tb_piarb_wrr_sch.sv
// Directed bench for piarb_wrr_sch: latency, WRR order, weights, in-flight cap, set/clear race, reset.
module tb_piarb_wrr_sch;

  logic       clk = 1'b0;
  logic       rst;
  logic       sch_en;
  logic       cfg_wr;
  logic [4:0] cfg_qid;
  logic [3:0] cfg_weight;
  logic       qm_enq_ack;
  logic       qm_enq_to_empty;
  logic [4:0] qm_enq_ack_qid;
  logic       sch_deq_depth_ack;
  logic       sch_deq_depth_from_emptyp2;
  logic       sch_deq;
  logic [4:0] sch_deq_qid;
  logic [2:0] inflight_cnt;
  logic       err_unexp_ack;

  int checks = 0;
  int errors = 0;
  int cnt_deq;

  always #5 clk = ~clk;

  piarb_wrr_sch dut (
    .clk                        (clk),
    .rst                        (rst),
    .sch_en                     (sch_en),
    .cfg_wr                     (cfg_wr),
    .cfg_qid                    (cfg_qid),
    .cfg_weight                 (cfg_weight),
    .qm_enq_ack                 (qm_enq_ack),
    .qm_enq_to_empty            (qm_enq_to_empty),
    .qm_enq_ack_qid             (qm_enq_ack_qid),
    .sch_deq_depth_ack          (sch_deq_depth_ack),
    .sch_deq_depth_from_emptyp2 (sch_deq_depth_from_emptyp2),
    .sch_deq                    (sch_deq),
    .sch_deq_qid                (sch_deq_qid),
    .inflight_cnt               (inflight_cnt),
    .err_unexp_ack              (err_unexp_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic enq(input logic [4:0] q);
    qm_enq_ack      = 1'b1;
    qm_enq_to_empty = 1'b1;
    qm_enq_ack_qid  = q;
    step();
    qm_enq_ack      = 1'b0;
    qm_enq_to_empty = 1'b0;
  endtask

  task automatic ack(input logic e2);
    sch_deq_depth_ack          = 1'b1;
    sch_deq_depth_from_emptyp2 = e2;
    step();
    sch_deq_depth_ack          = 1'b0;
    sch_deq_depth_from_emptyp2 = 1'b0;
  endtask

  task automatic wcfg(input logic [4:0] q, input logic [3:0] w);
    cfg_wr     = 1'b1;
    cfg_qid    = q;
    cfg_weight = w;
    step();
    cfg_wr     = 1'b0;
  endtask

  initial begin
    sch_en = 1'b0; cfg_wr = 1'b0; cfg_qid = 5'd0; cfg_weight = 4'd0;
    qm_enq_ack = 1'b0; qm_enq_to_empty = 1'b0; qm_enq_ack_qid = 5'd0;
    sch_deq_depth_ack = 1'b0; sch_deq_depth_from_emptyp2 = 1'b0;
    do_reset();
    chk("rst_deq", sch_deq, 0);
    chk("rst_qid", sch_deq_qid, 0);
    chk("rst_cnt", inflight_cnt, 0);
    chk("rst_err", err_unexp_ack, 0);

    // 1: enq-to-empty latency, hold until ack, reissue after emptyp2 ack, stop after final ack
    sch_en = 1'b1;
    enq(5'd3);
    chk("t1_t1_deq", sch_deq, 0);
    step();
    chk("t1_t2_deq", sch_deq, 1);
    chk("t1_t2_qid", sch_deq_qid, 3);
    chk("t1_t2_cnt", inflight_cnt, 1);
    step();
    chk("t1_t3_deq", sch_deq, 0);
    chk("t1_t3_qid_hold", sch_deq_qid, 3);
    step();
    chk("t1_t4_deq", sch_deq, 0);
    step();
    ack(1'b1);
    chk("t1_t6_deq", sch_deq, 0);
    chk("t1_t6_cnt", inflight_cnt, 0);
    step();
    chk("t1_t7_deq", sch_deq, 1);
    chk("t1_t7_qid", sch_deq_qid, 3);
    ack(1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_idle_deq", sch_deq, 0);
      chk("t1_idle_cnt", inflight_cnt, 0);
      step();
    end
    chk("t1_err", err_unexp_ack, 0);

    // 2: wrap-around order 0,5,31,0,5
    do_reset();
    enq(5'd0);
    enq(5'd5);
    chk("t2_g0_deq", sch_deq, 1);
    chk("t2_g0_qid", sch_deq_qid, 0);
    enq(5'd31);
    chk("t2_g1_qid", sch_deq_qid, 5);
    step();
    chk("t2_g2_deq", sch_deq, 1);
    chk("t2_g2_qid", sch_deq_qid, 31);
    ack(1'b1);
    chk("t2_gap_deq", sch_deq, 0);
    ack(1'b1);
    chk("t2_g3_deq", sch_deq, 1);
    chk("t2_g3_qid", sch_deq_qid, 0);
    ack(1'b1);
    chk("t2_g4_deq", sch_deq, 1);
    chk("t2_g4_qid", sch_deq_qid, 5);
    chk("t2_cnt", inflight_cnt, 2);

    // 3: weights q1=3, q2=1 give 1,1,1,2; then weight 0 on q2 behaves as 1
    do_reset();
    sch_en = 1'b0;
    wcfg(5'd1, 4'd3);
    wcfg(5'd2, 4'd1);
    enq(5'd1);
    enq(5'd2);
    for (int i = 0; i < 8; i++) begin
      sch_en = 1'b1;
      step();
      chk("t3_w1_deq", sch_deq, 1);
      chk("t3_w1_qid", sch_deq_qid, ((i % 4) == 3) ? 2 : 1);
      sch_en = 1'b0;
      ack(1'b1);
    end
    wcfg(5'd2, 4'd0);
    for (int i = 0; i < 8; i++) begin
      sch_en = 1'b1;
      step();
      chk("t3_w0_deq", sch_deq, 1);
      chk("t3_w0_qid", sch_deq_qid, ((i % 4) == 3) ? 2 : 1);
      sch_en = 1'b0;
      ack(1'b1);
    end

    // 4: in-flight cap of 4 with six active queues
    do_reset();
    sch_en = 1'b0;
    for (int q = 10; q < 16; q++) begin
      enq(5'(q));
    end
    sch_en  = 1'b1;
    cnt_deq = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (sch_deq) cnt_deq++;
    end
    chk("t4_grants", cnt_deq, 4);
    chk("t4_cnt_full", inflight_cnt, 4);
    ack(1'b1);
    chk("t4_ack_no_free_deq", sch_deq, 0);
    chk("t4_ack_cnt", inflight_cnt, 3);
    step();
    chk("t4_extra_deq", sch_deq, 1);
    chk("t4_extra_qid", sch_deq_qid, 14);
    chk("t4_extra_cnt", inflight_cnt, 4);
    cnt_deq = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (sch_deq) cnt_deq++;
    end
    chk("t4_stall", cnt_deq, 0);

    // 5: same-cycle clear-by-ack and set-by-enq on q7: set wins
    do_reset();
    enq(5'd7);
    step();
    chk("t5_first_deq", sch_deq, 1);
    chk("t5_first_qid", sch_deq_qid, 7);
    qm_enq_ack = 1'b1; qm_enq_to_empty = 1'b1; qm_enq_ack_qid = 5'd7;
    ack(1'b0);
    qm_enq_ack = 1'b0; qm_enq_to_empty = 1'b0;
    chk("t5_gap_deq", sch_deq, 0);
    step();
    chk("t5_regrant_deq", sch_deq, 1);
    chk("t5_regrant_qid", sch_deq_qid, 7);

    // 6: reset with three outstanding, then a stray ack
    do_reset();
    enq(5'd1);
    enq(5'd2);
    enq(5'd3);
    step();
    chk("t6_pre_cnt", inflight_cnt, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_deq", sch_deq, 0);
    chk("t6_rst_qid", sch_deq_qid, 0);
    chk("t6_rst_cnt", inflight_cnt, 0);
    chk("t6_rst_err", err_unexp_ack, 0);
    ack(1'b1);
    chk("t6_err_set", err_unexp_ack, 1);
    chk("t6_err_deq", sch_deq, 0);
    chk("t6_err_cnt", inflight_cnt, 0);
    step();
    chk("t6_err_sticky", err_unexp_ack, 1);
    chk("t6_err_deq2", sch_deq, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
